// File: rtl/ibex_register_file_fpga_mp.sv
// rtl/ibex_register_file_fpga_mp.sv - LUTRAM register file with N async read ports, one sync write port
// and a hardware clear sweep, since inferred LUTRAM has no reset.
module ibex_register_file_fpga_mp #(
    parameter int unsigned          NumRegs      = 32,
    parameter int unsigned          DataWidth    = 32,
    parameter int unsigned          NumReadPorts = 3,
    parameter bit                   WriteBypass  = 1'b0,
    parameter logic [DataWidth-1:0] WordZeroVal  = '0,
    localparam int unsigned         AddrW        = $clog2(NumRegs)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumReadPorts*AddrW-1:0]     raddr_i,
    output logic [NumReadPorts*DataWidth-1:0] rdata_o,
    input  logic [AddrW-1:0]                  waddr_i,
    input  logic [DataWidth-1:0]              wdata_i,
    input  logic                              we_i,
    input  logic                              clr_req_i,
    output logic                              busy_o,
    output logic                              err_o
);

    typedef enum logic {
        CLEAR,
        READY
    } state_e;

    localparam logic [AddrW-1:0] LastPtr  = AddrW'(NumRegs - 1);
    localparam logic [AddrW-1:0] FirstPtr = AddrW'(1);

    state_e               state_q, state_d;
    logic [AddrW-1:0]     ptr_q, ptr_d;
    logic                 err_q, err_d;
    logic                 wr_valid;
    logic                 mem_we;
    logic [AddrW-1:0]     mem_waddr;
    logic [DataWidth-1:0] mem_wdata;
    logic [DataWidth-1:0] mem_q [NumRegs];

    assign wr_valid = we_i && (waddr_i != '0);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = waddr_i;
        mem_wdata = wdata_i;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = WordZeroVal;
                ptr_d     = ptr_q + FirstPtr;
                err_d     = wr_valid;
                if (ptr_q == LastPtr) begin
                    state_d = READY;
                end
            end
            READY: begin
                // A clear request wins over a same-cycle write, which is then reported.
                if (clr_req_i) begin
                    state_d = CLEAR;
                    ptr_d   = FirstPtr;
                    err_d   = wr_valid;
                end else begin
                    mem_we = wr_valid;
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = FirstPtr;
            end
        endcase
        if (rst_i) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CLEAR;
            ptr_q   <= FirstPtr;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar p = 0; p < NumReadPorts; p++) begin : g_rd
        logic [AddrW-1:0]     raddr;
        logic [DataWidth-1:0] rdata;

        assign raddr = raddr_i[p*AddrW +: AddrW];

        // During the sweep the array still holds stale data, so mask it.
        always_comb begin
            if (raddr == '0) begin
                rdata = '0;
            end else if (state_q == CLEAR) begin
                rdata = WordZeroVal;
            end else if (WriteBypass && we_i && (waddr_i == raddr)) begin
                rdata = wdata_i;
            end else begin
                rdata = mem_q[raddr];
            end
        end

        assign rdata_o[p*DataWidth +: DataWidth] = rdata;
    end

    assign busy_o = (state_q == CLEAR);
    assign err_o  = err_q;

endmodule
